// File: rtl/xc_malu_long_seq_pkg.sv
// Shared definitions for the multi-precision arithmetic sequencer:
// state encoding, multiply step count and step-counter width.
package xc_malu_long_seq_pkg;

    localparam int MMUL_STEPS = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MDR    = 3'd1,
        S_MSUB_1 = 3'd2,
        S_MACC_1 = 3'd3,
        S_MMUL_2 = 3'd4,
        S_MMUL_1 = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MMUL_STEPS - 1);
    localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(MMUL_STEPS);

endpackage

// File: rtl/xc_malu_mul_step.sv
// One unsigned shift-add multiply step: the multiplier sits in acc[31:0]
// and is consumed LSB first while the partial product grows in acc[63:32].
module xc_malu_mul_step (
    input  logic [63:0] acc,
    input  logic [31:0] rs2,
    output logic [63:0] n_acc
);

    logic [32:0] s33;

    assign s33   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? rs2 : 32'd0)};
    assign n_acc = {s33, acc[31:1]};

endmodule

// File: rtl/xc_malu_long_seq.sv
// Sequencer for xc.madd.3 / xc.msub.3 / xc.macc / xc.mmul.3: owns acc, carry
// and the step counter, and strobes the external long-arithmetic datapath.
module xc_malu_long_seq
    import xc_malu_long_seq_pkg::*;
(
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        valid,
    input  logic        flush,
    input  logic        uop_madd,
    input  logic        uop_msub,
    input  logic        uop_macc,
    input  logic        uop_mmul,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] rs3,
    output logic        ready,
    output logic [63:0] result,
    output logic        fsm_init,
    output logic        fsm_mdr,
    output logic        fsm_msub_1,
    output logic        fsm_macc_1,
    output logic        fsm_mmul_1,
    output logic        fsm_mmul_2,
    output logic        fsm_done,
    output logic [63:0] acc,
    output logic        carry,
    output logic [5:0]  count,
    input  logic [63:0] l_n_acc,
    input  logic        l_n_carry,
    input  logic [63:0] l_result,
    input  logic        l_ready
);

    state_t             state;
    state_t             state_nxt;
    logic [63:0]        acc_nxt;
    logic               carry_nxt;
    logic [CNT_W-1:0]   count_nxt;
    logic [63:0]        mdr_acc;
    logic               abort;

    // rs3 is consumed only by the long datapath.
    logic unused_ops;
    assign unused_ops = ^rs3;

    xc_malu_mul_step u_mul_step (
        .acc   (acc),
        .rs2   (rs2),
        .n_acc (mdr_acc)
    );

    assign abort = flush | ~valid;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state <= S_IDLE;
            acc   <= 64'd0;
            carry <= 1'b0;
            count <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            carry <= carry_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        carry_nxt  = carry;
        count_nxt  = count;
        ready      = 1'b0;
        result     = acc;
        fsm_init   = 1'b0;
        fsm_mdr    = 1'b0;
        fsm_msub_1 = 1'b0;
        fsm_macc_1 = 1'b0;
        fsm_mmul_1 = 1'b0;
        fsm_mmul_2 = 1'b0;
        fsm_done   = 1'b0;

        unique case (state)
            S_IDLE: begin
                fsm_init = valid;
                if (valid && !flush) begin
                    if (uop_madd) begin
                        // madd completes in the datapath within this cycle.
                        ready  = l_ready;
                        result = l_result;
                    end else if (uop_msub) begin
                        acc_nxt   = l_n_acc;
                        carry_nxt = l_n_carry;
                        state_nxt = S_MSUB_1;
                    end else if (uop_macc) begin
                        acc_nxt   = l_n_acc;
                        carry_nxt = l_n_carry;
                        state_nxt = S_MACC_1;
                    end else if (uop_mmul) begin
                        acc_nxt   = {32'd0, rs1};
                        carry_nxt = 1'b0;
                        count_nxt = '0;
                        state_nxt = S_MDR;
                    end
                end
            end
            S_MDR: begin
                fsm_mdr   = 1'b1;
                acc_nxt   = mdr_acc;
                count_nxt = count + CNT_W'(1);
                if (count == LAST_STEP) begin
                    state_nxt = S_MMUL_2;
                end
            end
            S_MSUB_1: begin
                fsm_msub_1 = 1'b1;
                acc_nxt    = l_n_acc;
                carry_nxt  = l_n_carry;
                state_nxt  = S_DONE;
            end
            S_MACC_1: begin
                fsm_macc_1 = 1'b1;
                acc_nxt    = l_n_acc;
                carry_nxt  = l_n_carry;
                state_nxt  = S_DONE;
            end
            S_MMUL_2: begin
                fsm_mmul_2 = 1'b1;
                acc_nxt    = l_n_acc;
                carry_nxt  = l_n_carry;
                state_nxt  = S_MMUL_1;
            end
            S_MMUL_1: begin
                fsm_mmul_1 = 1'b1;
                acc_nxt    = l_n_acc;
                state_nxt  = S_DONE;
            end
            S_DONE: begin
                fsm_done  = 1'b1;
                ready     = 1'b1;
                result    = acc;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // An abandoned operation never reports ready and leaves clean state.
        if (state != S_IDLE && abort) begin
            ready     = 1'b0;
            state_nxt = S_IDLE;
            acc_nxt   = 64'd0;
            carry_nxt = 1'b0;
            count_nxt = '0;
        end
    end

    a_uop_onehot: assert property (@(posedge g_clk) disable iff (!g_resetn)
        valid |-> $onehot0({uop_madd, uop_msub, uop_macc, uop_mmul}));

    a_count_max: assert property (@(posedge g_clk) disable iff (!g_resetn)
        count <= MAX_COUNT);

endmodule
